// File: rtl/apb_memif_ctrl.sv
// APB slave to registered mreq/mack memory bridge with address-window decode,
// optional alignment checking and a request timeout that aborts the memory side.
module apb_memif_ctrl #(
    parameter int unsigned             ADDR_WIDTH     = 32,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter int unsigned             STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned             MRESP_WIDTH    = 2,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter longint unsigned         ADDR_SPAN      = 4096,
    parameter bit                      ALIGN_CHECK    = 1'b1,
    parameter int unsigned             TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   psel_i,
    input  logic                   penable_i,
    input  logic [ADDR_WIDTH-1:0]  paddr_i,
    input  logic                   pwrite_i,
    input  logic [DATA_WIDTH-1:0]  pwdata_i,
    input  logic [STRB_WIDTH-1:0]  pstrb_i,
    output logic                   pready_o,
    output logic [DATA_WIDTH-1:0]  prdata_o,
    output logic                   pslverr_o,
    output logic                   mreq_o,
    output logic [ADDR_WIDTH-1:0]  maddr_o,
    output logic                   mwe_o,
    output logic [DATA_WIDTH-1:0]  mwdata_o,
    output logic [STRB_WIDTH-1:0]  mstrb_o,
    output logic                   mabort_o,
    input  logic                   mack_i,
    input  logic [DATA_WIDTH-1:0]  mrdata_i,
    input  logic [MRESP_WIDTH-1:0] mresp_i,
    output logic                   err_decode_o,
    output logic                   err_timeout_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned LSB_W = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH:0] SPAN_EXT = (ADDR_WIDTH + 1)'(ADDR_SPAN);
    localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, BASE_ADDR};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    pready_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pslverr_q;
    logic                    mreq_q;
    logic [ADDR_WIDTH-1:0]   maddr_q;
    logic                    mwe_q;
    logic [DATA_WIDTH-1:0]   mwdata_q;
    logic [STRB_WIDTH-1:0]   mstrb_q;
    logic                    mabort_q;
    logic                    err_decode_q;
    logic                    err_timeout_q;

    logic [ADDR_WIDTH:0]     offs_ext_d;
    logic                    misalign_d;
    logic                    decode_err_d;
    logic                    unused_mresp;

    // Extra MSB keeps paddr - BASE_ADDR from wrapping into the window.
    assign offs_ext_d   = {1'b0, paddr_i} - BASE_EXT;
    assign decode_err_d = (paddr_i < BASE_ADDR) || (offs_ext_d >= SPAN_EXT) || misalign_d;
    assign unused_mresp = ^mresp_i;

    generate
        if (ALIGN_CHECK && (LSB_W > 0)) begin : g_align
            assign misalign_d = |paddr_i[LSB_W-1:0];
        end else begin : g_noalign
            assign misalign_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pready_q      <= 1'b0;
            prdata_q      <= '0;
            pslverr_q     <= 1'b0;
            mreq_q        <= 1'b0;
            maddr_q       <= '0;
            mwe_q         <= 1'b0;
            mwdata_q      <= '0;
            mstrb_q       <= '0;
            mabort_q      <= 1'b0;
            err_decode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            pready_q      <= 1'b0;
            mabort_q      <= 1'b0;
            err_decode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (psel_i && penable_i) begin
                        if (decode_err_d) begin
                            state_q      <= ST_RESP;
                            pready_q     <= 1'b1;
                            pslverr_q    <= 1'b1;
                            prdata_q     <= '0;
                            err_decode_q <= 1'b1;
                        end else begin
                            state_q  <= ST_REQ;
                            mreq_q   <= 1'b1;
                            maddr_q  <= offs_ext_d[ADDR_WIDTH-1:0];
                            mwe_q    <= pwrite_i;
                            mwdata_q <= pwdata_i;
                            mstrb_q  <= pstrb_i;
                            cnt_q    <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack in the timeout cycle still completes the access normally.
                    if (mack_i) begin
                        state_q   <= ST_RESP;
                        mreq_q    <= 1'b0;
                        pready_q  <= 1'b1;
                        prdata_q  <= mwe_q ? '0 : mrdata_i;
                        pslverr_q <= mresp_i[0];
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_q       <= ST_RESP;
                        mreq_q        <= 1'b0;
                        pready_q      <= 1'b1;
                        pslverr_q     <= 1'b1;
                        prdata_q      <= '0;
                        err_timeout_q <= 1'b1;
                        mabort_q      <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    mreq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pready_o      = pready_q;
    assign prdata_o      = prdata_q;
    assign pslverr_o     = pslverr_q;
    assign mreq_o        = mreq_q;
    assign maddr_o       = maddr_q;
    assign mwe_o         = mwe_q;
    assign mwdata_o      = mwdata_q;
    assign mstrb_o       = mstrb_q;
    assign mabort_o      = mabort_q;
    assign err_decode_o  = err_decode_q;
    assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_apb_memif_ctrl.sv
// Directed bench for apb_memif_ctrl: one instance with an 8-cycle timeout and
// one with the timeout disabled, both decoding a 4 KiB window at 0x1000.
module tb_apb_memif_ctrl;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic        use0 = 1'b0;
    logic        mack = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] mrdata = '0;
    logic [3:0]  pstrb = '0;
    logic [1:0]  mresp = '0;

    logic        a_pready, a_pslverr, a_mreq, a_mwe, a_mabort, a_dec, a_to;
    logic [31:0] a_prdata, a_maddr, a_mwdata;
    logic [3:0]  a_mstrb;
    logic        z_pready, z_pslverr, z_mreq, z_mwe, z_mabort, z_dec, z_to;
    logic [31:0] z_prdata, z_maddr, z_mwdata;
    logic [3:0]  z_mstrb;

    logic        pready, pslverr, mreq, mwe, mabort, edec, eto;
    logic [31:0] prdata, maddr, mwdata;
    logic [3:0]  mstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_memif_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MRESP_WIDTH(2), .BASE_ADDR(32'h1000),
        .ADDR_SPAN(4096), .ALIGN_CHECK(1'b1), .TIMEOUT_CYCLES(8)
    ) dut8 (
        .clk_i(clk), .arst_i(arst), .psel_i(psel & ~use0), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(a_pready), .prdata_o(a_prdata), .pslverr_o(a_pslverr),
        .mreq_o(a_mreq), .maddr_o(a_maddr), .mwe_o(a_mwe), .mwdata_o(a_mwdata),
        .mstrb_o(a_mstrb), .mabort_o(a_mabort), .mack_i(mack & ~use0),
        .mrdata_i(mrdata), .mresp_i(mresp), .err_decode_o(a_dec), .err_timeout_o(a_to)
    );

    apb_memif_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MRESP_WIDTH(2), .BASE_ADDR(32'h1000),
        .ADDR_SPAN(4096), .ALIGN_CHECK(1'b1), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .clk_i(clk), .arst_i(arst), .psel_i(psel & use0), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(z_pready), .prdata_o(z_prdata), .pslverr_o(z_pslverr),
        .mreq_o(z_mreq), .maddr_o(z_maddr), .mwe_o(z_mwe), .mwdata_o(z_mwdata),
        .mstrb_o(z_mstrb), .mabort_o(z_mabort), .mack_i(mack & use0),
        .mrdata_i(mrdata), .mresp_i(mresp), .err_decode_o(z_dec), .err_timeout_o(z_to)
    );

    assign pready  = use0 ? z_pready  : a_pready;
    assign pslverr = use0 ? z_pslverr : a_pslverr;
    assign prdata  = use0 ? z_prdata  : a_prdata;
    assign mreq    = use0 ? z_mreq    : a_mreq;
    assign maddr   = use0 ? z_maddr   : a_maddr;
    assign mwe     = use0 ? z_mwe     : a_mwe;
    assign mwdata  = use0 ? z_mwdata  : a_mwdata;
    assign mstrb   = use0 ? z_mstrb   : a_mstrb;
    assign mabort  = use0 ? z_mabort  : a_mabort;
    assign edec    = use0 ? z_dec     : a_dec;
    assign eto     = use0 ? z_to      : a_to;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          k;
        logic [31:0] mrd;
        logic [1:0]  rsp;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic        exp_dec;
        logic        exp_to;
        int          exp_mreq;
        logic [31:0] exp_maddr;
    } vec_t;

    int          r_lat, r_mreq;
    logic        r_got, r_err, r_dec, r_to, r_abort, r_mwe, r_unstable;
    logic [31:0] r_rdata, r_maddr, r_mwdata;
    logic [3:0]  r_mstrb;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One APB transfer; the memory model acks on mreq cycle index k (k<0: never).
    task automatic xfer(input string nm, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st, input int k,
                        input logic [31:0] rd, input logic [1:0] rsp, input int budget);
        int cyc;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; pstrb = st;
        mrdata = rd; mresp = rsp;
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0; r_got = 1'b0; r_mreq = 0; r_unstable = 1'b0; r_lat = -1;
        while (!r_got && cyc < budget) begin
            @(negedge clk);
            mack = 1'b0;
            if (mreq) begin
                if (r_mreq == 0) begin
                    r_maddr = maddr; r_mwe = mwe; r_mwdata = mwdata; r_mstrb = mstrb;
                end else if (maddr !== r_maddr || mwe !== r_mwe || mwdata !== r_mwdata ||
                             mstrb !== r_mstrb) begin
                    r_unstable = 1'b1;
                end
                if (r_mreq == k) mack = 1'b1;
                r_mreq++;
            end
            if (pready) begin
                r_got = 1'b1; r_lat = cyc; r_err = pslverr; r_rdata = prdata;
                r_dec = edec; r_to = eto; r_abort = mabort;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mack = 1'b0; psel = 1'b0; penable = 1'b0;
        check({nm, ".responded"}, r_got, 1);
        @(negedge clk);
        check({nm, ".pready_one_cycle"}, pready, 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"read",     32'h1004, 1'b0, 32'h0,        4'hF, 2,  32'hCAFEF00D, 2'b00, 4, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 3, 32'h004};
        vecs[1] = '{"write",    32'h1008, 1'b1, 32'h12345678, 4'h5, 0,  32'h99999999, 2'b01, 2, 1'b1, 32'h0,        1'b0, 1'b0, 1, 32'h008};
        vecs[2] = '{"dec_low",  32'h0FFC, 1'b0, 32'h0,        4'hF, 0,  32'h0,        2'b00, 1, 1'b1, 32'h0,        1'b1, 1'b0, 0, 32'h0};
        vecs[3] = '{"dec_high", 32'h2000, 1'b1, 32'h1,        4'hF, 0,  32'h0,        2'b00, 1, 1'b1, 32'h0,        1'b1, 1'b0, 0, 32'h0};
        vecs[4] = '{"dec_align",32'h1002, 1'b0, 32'h0,        4'hF, 0,  32'h0,        2'b00, 1, 1'b1, 32'h0,        1'b1, 1'b0, 0, 32'h0};
        vecs[5] = '{"top_word", 32'h1FFC, 1'b0, 32'h0,        4'hF, 1,  32'hA5A55A5A, 2'b10, 3, 1'b0, 32'hA5A55A5A, 1'b0, 1'b0, 2, 32'hFFC};
        vecs[6] = '{"race",     32'h1000, 1'b0, 32'h0,        4'hF, 7,  32'h11112222, 2'b00, 9, 1'b0, 32'h11112222, 1'b0, 1'b0, 8, 32'h000};
        vecs[7] = '{"wr_zero",  32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 3,  32'h00000055, 2'b00, 5, 1'b0, 32'h0,        1'b0, 1'b0, 4, 32'h000};
        vecs[8] = '{"timeout",  32'h1010, 1'b0, 32'h0,        4'h3, -1, 32'h77777777, 2'b00, 9, 1'b1, 32'h0,        1'b0, 1'b1, 8, 32'h010};

        #12;
        check("rst.pready", pready, 0);
        check("rst.mreq", mreq, 0);
        check("rst.prdata", prdata, 0);
        check("rst.flags", {pslverr, mabort, edec, eto, mwe}, 0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].k, vecs[i].mrd, vecs[i].rsp, 40);
            check({vecs[i].name, ".latency"}, r_lat, vecs[i].exp_lat);
            check({vecs[i].name, ".pslverr"}, r_err, vecs[i].exp_err);
            check({vecs[i].name, ".prdata"}, r_rdata, vecs[i].exp_rdata);
            check({vecs[i].name, ".err_decode"}, r_dec, vecs[i].exp_dec);
            check({vecs[i].name, ".err_timeout"}, r_to, vecs[i].exp_to);
            check({vecs[i].name, ".mabort"}, r_abort, vecs[i].exp_to);
            check({vecs[i].name, ".mreq_cycles"}, r_mreq, vecs[i].exp_mreq);
            if (vecs[i].exp_mreq > 0) begin
                check({vecs[i].name, ".maddr"}, r_maddr, vecs[i].exp_maddr);
                check({vecs[i].name, ".mwe"}, r_mwe, vecs[i].wr);
                check({vecs[i].name, ".mwdata"}, r_mwdata, vecs[i].wdata);
                check({vecs[i].name, ".mstrb"}, r_mstrb, vecs[i].strb);
                check({vecs[i].name, ".stable"}, r_unstable, 0);
            end
        end

        // Late ack two cycles after the timeout response must be ignored.
        @(negedge clk);
        mack = 1'b1;
        @(negedge clk);
        mack = 1'b0;
        check("late_ack.mreq", mreq, 0);
        check("late_ack.pready", pready, 0);
        @(negedge clk);
        check("late_ack.pready_next", {pready, pslverr, mabort}, 0);
        xfer("after_to", 32'h1020, 1'b0, 32'h0, 4'hF, 1, 32'h0BADF00D, 2'b00, 40);
        check("after_to.latency", r_lat, 3);
        check("after_to.prdata", r_rdata, 32'h0BADF00D);
        check("after_to.pslverr", r_err, 0);
        check("after_to.maddr", r_maddr, 32'h020);

        // Reset while a request is outstanding.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 32'h1030; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.mreq_before", mreq, 1);
        #2 arst = 1'b1;
        #1;
        check("rst_mid.mreq", mreq, 0);
        check("rst_mid.pready", pready, 0);
        check("rst_mid.maddr", maddr, 0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        arst = 1'b0;
        @(negedge clk);
        check("rst_mid.no_resp", {pready, mreq}, 0);
        xfer("post_rst", 32'h1034, 1'b0, 32'h0, 4'hF, 0, 32'h600DCAFE, 2'b00, 40);
        check("post_rst.latency", r_lat, 2);
        check("post_rst.prdata", r_rdata, 32'h600DCAFE);
        check("post_rst.maddr", r_maddr, 32'h034);

        // Timeout disabled: an ack after 1000 request cycles still completes.
        use0 = 1'b1;
        xfer("no_to", 32'h1040, 1'b0, 32'h0, 4'hF, 999, 32'h13572468, 2'b00, 1100);
        check("no_to.latency", r_lat, 1001);
        check("no_to.mreq_cycles", r_mreq, 1000);
        check("no_to.prdata", r_rdata, 32'h13572468);
        check("no_to.flags", {r_err, r_to, r_abort}, 0);
        use0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
